// File: rtl/spi_resp16.sv
// SPI responder (slave): SS_n active low, SCLK idle high, MSB-first frames,
// data driven on SCLK fall and sampled on SCLK rise; inputs oversampled by clk.
module spi_resp16 #(
  parameter int DATA_W   = 16,
  parameter int SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rdy,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    HOLD
  } state_t;

  state_t state, state_next;

  // Stages [SYNC_STG-1:0] are the synchronizer, stage [SYNC_STG] is the edge-detect flop.
  logic [SYNC_STG:0] sclk_pipe, ss_pipe, mosi_pipe;

  logic sclk_s, sclk_d, ss_s, ss_d, mosi_s;
  logic rise, fall, ss_fall;

  logic [DATA_W-1:0] rx_shft, tx_shft;
  logic [CNT_W-1:0]  bit_cnt;

  logic load, shift_rx, shift_tx, done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_pipe <= '1;
      ss_pipe   <= '1;
      mosi_pipe <= '1;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STG-1:0], SCLK};
      ss_pipe   <= {ss_pipe[SYNC_STG-1:0], SS_n};
      mosi_pipe <= {mosi_pipe[SYNC_STG-1:0], MOSI};
    end
  end

  assign sclk_s = sclk_pipe[SYNC_STG-1];
  assign sclk_d = sclk_pipe[SYNC_STG];
  assign ss_s   = ss_pipe[SYNC_STG-1];
  assign ss_d   = ss_pipe[SYNC_STG];
  // MOSI has the same total depth, so this sample predates the detected
  // SCLK rise by one raw clk and is safely before the master changes it.
  assign mosi_s = mosi_pipe[SYNC_STG];

  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign ss_fall = ~ss_s & ss_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // One event per clk, in priority order: SS_n high, ss_fall, rise, fall.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_rx   = 1'b0;
    shift_tx   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (!ss_s && ss_fall) begin
          load       = 1'b1;
          state_next = XFER;
        end
      end
      XFER: begin
        if (ss_s) begin
          state_next = IDLE;
        end else if (rise) begin
          shift_rx = 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            done       = 1'b1;
            state_next = HOLD;
          end
        end else if (fall && (bit_cnt != '0)) begin
          shift_tx = 1'b1;
        end
      end
      HOLD: begin
        if (ss_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shft <= '0;
      tx_shft <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
      rdy     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      rdy  <= done;
      busy <= (state_next != IDLE);
      if (load) begin
        tx_shft <= tx_data;
        rx_shft <= '0;
        bit_cnt <= '0;
      end
      if (shift_rx) begin
        rx_shft <= {rx_shft[DATA_W-2:0], mosi_s};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (done) begin
        rx_data <= {rx_shft[DATA_W-2:0], mosi_s};
      end
      if (shift_tx) begin
        tx_shft <= {tx_shft[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign MISO = (state != IDLE) ? tx_shft[DATA_W-1] : 1'b1;

endmodule
